// File: rtl/hsid_x_obi_inf_pkg.sv
// OBI interface types and default widths shared by the HSID OBI blocks.
//   obi_req_t  : manager request (req, we, be, addr, wdata)
//   obi_resp_t : subordinate response (gnt, rvalid, rdata, err)
package hsid_x_obi_inf_pkg;

  localparam int unsigned HSID_WORD_WIDTH       = 32;
  localparam int unsigned HSID_MEM_ACCESS_WIDTH = 16;

  typedef struct packed {
    logic                           req;
    logic                           we;
    logic [HSID_WORD_WIDTH/8-1:0]   be;
    logic [HSID_WORD_WIDTH-1:0]     addr;
    logic [HSID_WORD_WIDTH-1:0]     wdata;
  } obi_req_t;

  typedef struct packed {
    logic                       gnt;
    logic                       rvalid;
    logic [HSID_WORD_WIDTH-1:0] rdata;
    logic                       err;
  } obi_resp_t;

endpackage

// File: rtl/hsid_x_obi_stream_reader.sv
// Strided OBI read engine feeding a small output FIFO.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   obi_req / obi_rsp          OBI manager read port (we=0, be all-ones, wdata=0)
//   initial_addr, stride       first byte address and byte step between reads
//   limit                      number of words to read (0 = all-ones)
//   start, clear               command pulses
//   idle, ready, done          status: IDLE, READING, DONE respectively
//   data_out_valid/_ready, data_out   output stream (FIFO head)
//   error                      sticky: an OBI response carried err
module hsid_x_obi_stream_reader
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int unsigned WORD_WIDTH       = HSID_WORD_WIDTH,
  parameter int unsigned MEM_ACCESS_WIDTH = HSID_MEM_ACCESS_WIDTH,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output obi_req_t                    obi_req,
  input  obi_resp_t                   obi_rsp,
  input  logic [WORD_WIDTH-1:0]       initial_addr,
  input  logic [WORD_WIDTH-1:0]       stride,
  input  logic [MEM_ACCESS_WIDTH-1:0] limit,
  input  logic                        start,
  input  logic                        clear,
  output logic                        idle,
  output logic                        ready,
  output logic                        done,
  output logic                        data_out_valid,
  output logic [WORD_WIDTH-1:0]       data_out,
  input  logic                        data_out_ready,
  output logic                        error
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OutW = PtrW + 1;
  localparam int unsigned SumW = OutW + 1;
  localparam int unsigned CntW = MEM_ACCESS_WIDTH + 1;
  localparam logic [SumW-1:0] DepthSum = SumW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StInit, StReading, StDone, StClear} state_e;

  state_e                      state_q, state_d;
  logic [WORD_WIDTH-1:0]       addr_q, addr_d;
  logic [WORD_WIDTH-1:0]       stride_q, stride_d;
  logic [MEM_ACCESS_WIDTH-1:0] limit_q, limit_d;
  logic [CntW-1:0]             requests_q, requests_d;
  logic [CntW-1:0]             reads_q, reads_d;
  logic [OutW-1:0]             outstanding_q, outstanding_d;
  logic [OutW-1:0]             count_q, count_d;
  logic [PtrW-1:0]             wptr_q, wptr_d;
  logic [PtrW-1:0]             rptr_q, rptr_d;
  logic                        error_q, error_d;
  logic [WORD_WIDTH-1:0]       mem_q [FIFO_DEPTH];

  logic req_en, gnt_hs, rvalid_ok, push, pop, flush;

  // Credit rule: in-flight reads plus buffered words never exceed the FIFO,
  // so every rvalid always has a free slot.
  assign req_en = (state_q == StReading) && (requests_q < {1'b0, limit_q}) &&
                  (({1'b0, outstanding_q} + {1'b0, count_q}) < DepthSum);
  assign gnt_hs    = req_en && obi_rsp.gnt;
  assign rvalid_ok = obi_rsp.rvalid && (outstanding_q != '0);
  assign data_out_valid = (count_q != '0);
  assign pop            = data_out_valid && data_out_ready;
  assign data_out       = data_out_valid ? mem_q[rptr_q] : '0;

  always_comb begin
    obi_req      = '0;
    obi_req.req  = req_en;
    obi_req.be   = '1;
    obi_req.addr = addr_q;
  end

  assign idle  = (state_q == StIdle);
  assign ready = (state_q == StReading);
  assign done  = (state_q == StDone);
  assign error = error_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    limit_d       = limit_q;
    requests_d    = requests_q;
    reads_d       = reads_q;
    error_d       = error_q;
    push          = 1'b0;
    flush         = 1'b0;
    outstanding_d = outstanding_q + OutW'(gnt_hs) - OutW'(rvalid_ok);

    if (gnt_hs) begin
      requests_d = requests_q + CntW'(1);
      addr_d     = addr_q + stride_q;
    end
    if (obi_rsp.rvalid && obi_rsp.err && (state_q != StIdle)) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start && !clear) state_d = StInit;
      end
      StInit: begin
        addr_d     = initial_addr;
        stride_d   = stride;
        limit_d    = (limit == '0) ? '1 : limit;
        requests_d = '0;
        reads_d    = '0;
        error_d    = 1'b0;
        if (clear) begin
          state_d = StClear;
          flush   = 1'b1;
        end else begin
          state_d = StReading;
        end
      end
      StReading: begin
        if (clear) begin
          state_d = StClear;
          flush   = 1'b1;
        end else begin
          if (rvalid_ok) begin
            push    = 1'b1;
            reads_d = reads_q + CntW'(1);
          end
          if ((reads_q == {1'b0, limit_q}) && (count_q == '0)) state_d = StDone;
        end
      end
      StDone: begin
        if (clear) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StInit;
        end
      end
      StClear: begin
        // Late responses are drained and dropped; leave only once nothing is in flight.
        flush      = 1'b1;
        addr_d     = '0;
        stride_d   = '0;
        limit_d    = '0;
        requests_d = '0;
        reads_d    = '0;
        if (outstanding_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + OutW'(push) - OutW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      stride_q      <= '0;
      limit_q       <= '0;
      requests_q    <= '0;
      reads_q       <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      limit_q       <= limit_d;
      requests_q    <= requests_d;
      reads_q       <= reads_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      error_q       <= error_d;
    end
  end

  // Storage needs no reset: data_out is gated by the (reset) occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= obi_rsp.rdata;
  end

endmodule

// File: tb/tb_hsid_x_obi_stream_reader.sv
// Randomized scoreboard bench for hsid_x_obi_stream_reader with an OBI memory model.
module tb_hsid_x_obi_stream_reader;
  import hsid_x_obi_inf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  obi_req_t    obi_req;
  obi_resp_t   obi_rsp;
  logic [31:0] initial_addr, stride;
  logic [15:0] limit;
  logic        start, clear;
  logic        idle, ready, done;
  logic        data_out_valid, data_out_ready;
  logic [31:0] data_out;
  logic        error;

  hsid_x_obi_stream_reader #(
    .WORD_WIDTH(32), .MEM_ACCESS_WIDTH(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .obi_req(obi_req), .obi_rsp(obi_rsp),
    .initial_addr(initial_addr), .stride(stride), .limit(limit),
    .start(start), .clear(clear), .idle(idle), .ready(ready), .done(done),
    .data_out_valid(data_out_valid), .data_out(data_out),
    .data_out_ready(data_out_ready), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Memory contents as a pure function of byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  rsp_t        pend_q[$];
  int gnt_pct = 100, rdy_pct = 100, lat_min = 0, lat_max = 0, err_idx = -1;
  int rsp_cnt = 0, grants = 0, cyc = 0;
  bit no_data_chk = 0;

  // OBI subordinate + output monitor. Everything here is decided on the falling
  // edge for the following rising edge, so handshakes are known in advance.
  bit          prev_stall = 0, prev_wait = 0;
  logic [31:0] prev_data, prev_addr;
  rsp_t        r, nr;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend_q.delete();
      obi_rsp        = '0;
      data_out_ready = 1'b0;
      prev_stall     = 0;
      prev_wait      = 0;
    end else begin
      data_out_ready = ($urandom_range(99) < rdy_pct);
      if (data_out_valid) begin
        if (no_data_chk) fail("valid_during_clear");
        if (prev_stall) check("data_hold", data_out, prev_data);
        if (data_out_ready) begin
          if (exp_data_q.size() == 0) fail("unexpected_data");
          else check("data", data_out, exp_data_q.pop_front());
        end
      end
      prev_stall = data_out_valid && !data_out_ready;
      prev_data  = data_out;

      if (prev_wait && ready) begin
        check("req_held", obi_req.req, 1);
        check("addr_held", obi_req.addr, prev_addr);
      end

      obi_rsp.rvalid = 1'b0;
      obi_rsp.rdata  = '0;
      obi_rsp.err    = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        obi_rsp.rvalid = 1'b1;
        obi_rsp.rdata  = r.data;
        obi_rsp.err    = r.err;
      end

      obi_rsp.gnt = ($urandom_range(99) < gnt_pct);
      prev_wait = obi_req.req && !obi_rsp.gnt;
      prev_addr = obi_req.addr;
      if (obi_req.req && obi_rsp.gnt) begin
        grants++;
        if (exp_addr_q.size() == 0) fail("unexpected_grant");
        else check("addr", obi_req.addr, exp_addr_q.pop_front());
        nr.due  = cyc + 1 + lat_min + $urandom_range(lat_max);
        nr.data = mem_word(obi_req.addr);
        nr.err  = (rsp_cnt == err_idx);
        pend_q.push_back(nr);
        rsp_cnt++;
      end
    end
  end

  // Reference: the i-th word comes from (addr + i*stride) mod 2^32.
  task automatic do_start(input logic [31:0] a, input logic [31:0] s, input logic [15:0] lim);
    int n;
    logic [31:0] ai;
    n = (lim == 0) ? 64 : int'(lim);
    for (int i = 0; i < n; i++) begin
      ai = a + s * 32'(i);
      exp_addr_q.push_back(ai);
      exp_data_q.push_back(mem_word(ai));
    end
    initial_addr = a;
    stride       = s;
    limit        = lim;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return idle;
      1: return ready;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string nm, input int bound);
    int n = 0;
    while (!sig(which) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!sig(which)) fail(nm);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic flush_model();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  int g0;
  logic [15:0] rl;

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; obi_rsp = '0; data_out_ready = 1'b0;
    initial_addr = '0; stride = '0; limit = '0;
    #1;
    check("rst_idle", idle, 1);
    check("rst_req", obi_req.req, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_error", error, 0);
    check("rst_ready_done", {ready, done}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic three-word read at 0x100 stride 4.
    g0 = grants;
    do_start(32'h100, 32'd4, 16'd3);
    check("init_status", {idle, ready, done}, 0);
    @(negedge clk);
    check("reading_ready", ready, 1);
    wait_sig(2, "done_basic", 200);
    check("basic_grants", grants - g0, 3);
    check("basic_drained", exp_data_q.size(), 0);
    check("done_status", {idle, ready}, 0);
    pulse_clear();
    check("done_clear_idle", idle, 1);

    // Backpressure: only FIFO_DEPTH reads may be in flight or buffered.
    rdy_pct = 0;
    g0 = grants;
    do_start(32'h1000, 32'd8, 16'd8);
    repeat (30) @(negedge clk);
    check("bp_grants", grants - g0, 4);
    check("bp_req_low", obi_req.req, 0);
    rdy_pct = 100;
    wait_sig(2, "done_bp", 300);
    check("bp_all_grants", grants - g0, 8);
    check("bp_drained", exp_data_q.size(), 0);

    // Restart from DONE with err on the second response.
    err_idx = rsp_cnt + 1;
    do_start(32'h2000, 32'd12, 16'd3);
    wait_sig(2, "done_err", 200);
    check("error_sticky", error, 1);
    err_idx = -1;
    do_start(32'h2100, 32'd4, 16'd2);
    @(negedge clk);
    check("error_cleared", error, 0);
    wait_sig(2, "done_after_err", 200);
    check("err_run_drained", exp_data_q.size(), 0);
    pulse_clear();
    wait_sig(0, "idle_after_err", 20);

    // limit=0 means all-ones: req stays high with gnt always.
    do_start(32'h40, 32'd4, 16'd0);
    @(negedge clk);
    begin
      int low = 0;
      for (int i = 0; i < 20; i++) begin
        if (!obi_req.req) low++;
        @(negedge clk);
      end
      check("req_continuous_lowcycles", low, 0);
    end
    pulse_clear();
    wait_sig(0, "idle_after_unlimited", 100);
    flush_model();

    // Clear with two reads still in flight.
    lat_min = 8;
    g0 = grants;
    do_start(32'h300, 32'd4, 16'd2);
    begin
      int n = 0;
      while ((grants - g0) < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if ((grants - g0) < 2) fail("clear_setup_grants");
    end
    @(negedge clk);
    clear = 1'b1;
    no_data_chk = 1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_status", {idle, ready, done}, 0);
    wait_sig(0, "idle_after_clear", 100);
    check("clear_waited_rvalid", pend_q.size(), 0);
    check("clear_valid", data_out_valid, 0);
    check("clear_data", data_out, 0);
    check("clear_addr", obi_req.addr, 0);
    no_data_chk = 0;
    lat_min = 0;
    flush_model();

    // start && clear together in IDLE is ignored.
    @(negedge clk);
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check("start_clear_idle", {idle, ready}, 2'b10);

    // Asynchronous reset in the middle of a read.
    lat_min = 5;
    do_start(32'h500, 32'd4, 16'd4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_idle", idle, 1);
    check("midrst_req", obi_req.req, 0);
    check("midrst_valid", data_out_valid, 0);
    @(negedge clk);
    flush_model();
    @(negedge clk);
    flush_model();
    rst_n = 1'b1;
    lat_min = 0;

    // Randomized runs.
    for (int it = 0; it < 12; it++) begin
      gnt_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 30);
      lat_max = $urandom_range(3);
      rl = 16'($urandom_range(20, 1));
      g0 = grants;
      do_start($urandom, $urandom, rl);
      wait_sig(2, "done_random", 3000);
      check("rand_grants", grants - g0, rl);
      check("rand_drained", exp_data_q.size() + exp_addr_q.size(), 0);
      pulse_clear();
      wait_sig(0, "idle_random", 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsid_x_obi_stream_reader.md
HSID_X_OBI_STREAM_READER -- requirements
Module: hsid_x_obi_stream_reader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default HSID_WORD_WIDTH, meaning data/address width in bits.
REQ-002 SHALL have parameter MEM_ACCESS_WIDTH, default HSID_MEM_ACCESS_WIDTH, meaning word-count width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer depth and maximum outstanding OBI reads (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; reset is asynchronous and active-low.
REQ-006 SHALL have port obi_req, output, hsid_x_obi_inf_pkg::obi_req_t, meaning OBI manager request (we=0, be all-ones, wdata=0 always).
REQ-007 SHALL have port obi_rsp, input, hsid_x_obi_inf_pkg::obi_resp_t, meaning OBI response (gnt, rvalid, rdata, err).
REQ-008 SHALL have port initial_addr, input, WORD_WIDTH, meaning first byte address.
REQ-009 SHALL have port stride, input, WORD_WIDTH, meaning byte increment between requests.
REQ-010 SHALL have port limit, input, MEM_ACCESS_WIDTH, meaning words to read; 0 means all-ones.
REQ-011 SHALL have ports start and clear, input, 1 each, meaning command pulses.
REQ-012 SHALL have ports idle, ready and done, output, 1 each, meaning status handshake.
REQ-013 SHALL have ports data_out_valid (output, 1), data_out (output, WORD_WIDTH) and data_out_ready (input, 1), meaning the output stream.
REQ-014 SHALL have port error, output, 1, meaning sticky OBI err seen.

Function
REQ-015 SHALL implement states IDLE, INIT, READING, DONE, CLEAR.
REQ-016 SHALL move IDLE->INIT on start && !clear; start && clear in IDLE SHALL keep IDLE.
REQ-017 SHALL, in INIT, latch initial_addr, stride and limit (0 -> all-ones), zero requests, reads and error, then go to READING next cycle.
REQ-018 SHALL assert obi_req.req in READING iff requests < current_limit && (outstanding + fifo_count) < FIFO_DEPTH.
REQ-019 SHALL hold obi_req.req and obi_req.addr stable while req && !gnt.
REQ-020 SHALL, on req && gnt, increment requests by 1 and addr by stride, wrapping modulo 2^WORD_WIDTH.
REQ-021 SHALL, on rvalid, push rdata into the FIFO and increment reads; data_out_valid SHALL rise in the cycle after rvalid when the FIFO was empty.
REQ-022 SHALL present the FIFO head on data_out while data_out_valid and pop on data_out_valid && data_out_ready; data_out SHALL hold while valid && !ready.
REQ-023 SHALL never overflow the FIFO; the credit rule of REQ-018 SHALL guarantee this with gnt/rvalid/pop in the same cycle.
REQ-024 SHALL size requests and reads to MEM_ACCESS_WIDTH+1 bits and outstanding to $clog2(FIFO_DEPTH)+1 bits.
REQ-025 SHALL go READING->DONE when reads == current_limit and the FIFO is empty.
REQ-026 SHALL, in DONE, go to INIT on start && !clear and to IDLE on clear.
REQ-027 SHALL, on clear in INIT or READING, enter CLEAR next cycle with req low from that cycle on.
REQ-028 SHALL, in CLEAR, accept and discard rvalid data, flush the FIFO, and go to IDLE the cycle after outstanding == 0, with counters, addr, current_limit and data_out all zero.
REQ-029 SHALL drive idle=1 only in IDLE, ready=1 only in READING, done=1 only in DONE, all low in INIT and CLEAR.
REQ-030 SHALL set error on rvalid && err (data still pushed), holding it until INIT.
REQ-031 SHALL ignore start outside IDLE and DONE.

Reset
REQ-032 SHALL, on rst_n low, immediately enter IDLE with req, data_out_valid, data_out, error, counters and FIFO cleared and idle=1.
REQ-033 SHALL, on reset mid-READING, abandon outstanding transactions without waiting for rvalid.

Verification
REQ-034 limit=3, stride=4, addr=0x100, gnt always, rvalid 1 cycle later, ready=1 -> addrs 0x100,0x104,0x108; three data beats; DONE.
REQ-035 limit=8, FIFO_DEPTH=4, data_out_ready=0 -> exactly 4 grants then req low; after ready=1, all 8 words in order, DONE.
REQ-036 limit=0 -> current_limit all-ones; req high continuously with gnt=1.
REQ-037 clear in READING with 2 outstanding -> CLEAR until both rvalid, no data_out_valid, then IDLE with all zero.
REQ-038 start && clear in IDLE -> stays IDLE; err=1 on 2nd rvalid -> error=1 until next start.
